// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Five-digit BCD multiplexed 7-segment scanner over eight anode
//            slots, with frame-synchronous shadowing and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int TICK_DIV = 12500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] bcd_in,
  input  logic        blank_lz,
  input  logic        en,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int                 c_cnt_w   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TICK_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_idx;
  logic [19:0]        r_shadow;

  logic        w_tick;
  logic        w_frame_end;
  logic [19:0] w_shifted;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic        w_active;
  logic [6:0]  w_glyph;

  assign w_tick      = (r_cnt == c_cnt_max);
  assign w_frame_end = w_tick && (r_idx == 3'd7);

  // Shadow shifted down to the current digit: the low nibble is the digit,
  // and an all-zero remainder means this digit and all above it are zero.
  assign w_shifted = r_shadow >> {r_idx, 2'b00};
  assign w_digit   = w_shifted[3:0];
  assign w_blank   = blank_lz && (r_idx != 3'd0) && (w_shifted == 20'd0);
  assign w_active  = en && (r_cnt != '0) && (r_idx < 3'd5) && !w_blank;

  always_comb begin
    w_glyph = 7'b0111111;
    case (w_digit)
      4'd0:    w_glyph = 7'b1000000;
      4'd1:    w_glyph = 7'b1111001;
      4'd2:    w_glyph = 7'b0100100;
      4'd3:    w_glyph = 7'b0110000;
      4'd4:    w_glyph = 7'b0011001;
      4'd5:    w_glyph = 7'b0010010;
      4'd6:    w_glyph = 7'b0000010;
      4'd7:    w_glyph = 7'b1111000;
      4'd8:    w_glyph = 7'b0000000;
      4'd9:    w_glyph = 7'b0010000;
      default: w_glyph = 7'b0111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      r_shadow   <= 20'd0;
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + c_cnt_w'(1);
      if (w_tick) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_frame_end) begin
        r_shadow <= bcd_in;
      end
      frame_done <= w_frame_end;
      an         <= w_active ? ~(8'b0000_0001 << r_idx) : 8'hFF;
      seg        <= w_active ? w_glyph : 7'h7F;
      dp         <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter: TICK_DIV, default 12500, clock cycles per digit slot; legal range >= 2.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 bcd_in  input  20  five packed BCD digits; [3:0] is digit 0 (ones) and [19:16] is digit 4.
REQ-005 blank_lz  input  1  1 = leading-zero blanking enabled.
REQ-006 en  input  1  display enable; 0 forces all anodes off.
REQ-007 an  output  8  anode selects, active-low, one bit per display position.
REQ-008 seg  output  7  segment drives, active-low; bit order [6:0] = g,f,e,d,c,b,a.
REQ-009 dp  output  1  decimal point, active-low.
REQ-010 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-011 Prescaler cnt SHALL count 0..TICK_DIV-1 and then wrap to 0; tick = (cnt == TICK_DIV-1).
REQ-012 Digit index idx (3 bits) SHALL increment on tick and wrap from 7 to 0; one frame = 8*TICK_DIV cycles.
REQ-013 Shadow register SHALL load bcd_in on the edge where tick && idx==7, and hold at all other times, so no frame ever mixes two values.
REQ-014 frame_done SHALL be registered and high for exactly the one cycle following the edge on which tick && idx==7.
REQ-015 an, seg and dp SHALL be registers computed from the current cnt, idx and shadow, giving one clock of latency.
REQ-016 an SHALL be 8'hFF when any of the following holds: cnt==0 (anti-ghost gap at slot start), en==0, idx>=5, or the digit is blanked.
REQ-017 Otherwise an SHALL equal the bitwise inverse of (1 << idx).
REQ-018 Digit k (1..4) is blanked iff blank_lz==1 and shadow digits k..4 are all zero; digit 0 is never blanked.
REQ-019 seg encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 A nibble value 10..15 SHALL display '-' (0111111).
REQ-021 When an==8'hFF, seg SHALL be 7'h7F.
REQ-022 dp SHALL be constant 1 (off).
REQ-023 en does not stop cnt, idx, shadow loading or frame_done; only an and seg are affected.
REQ-024 blank_lz SHALL be sampled every cycle, not snapshotted.

Reset
REQ-025 While rst==1 at a clock edge: cnt=0, idx=0, shadow=0, an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
REQ-026 rst SHALL override all other inputs at that edge, including a coincident tick at idx==7, which then does not load shadow.
REQ-027 Reset asserted mid-frame SHALL abort the frame.
REQ-028 After reset release, the first frame SHALL display the reset shadow (digit 0 shows "0").
REQ-029 The first frame_done SHALL occur 8*TICK_DIV cycles after reset release.

Verification (TICK_DIV=4)
REQ-030 Hold bcd_in=20'h12345, blank_lz=0, en=1 and run past the first frame_done -> digit-0 slot: an=11111110, seg=0010010; digit-4 slot: an=11101111, seg=1111001; slots 5-7: an=FF; each slot shows 1 cycle an=FF, then 3 active cycles.
REQ-031 bcd_in=20'h00007, blank_lz=1 -> only an[0] ever asserted, seg=1111000; with blank_lz=0 -> digits 1-4 asserted, seg=1000000.
REQ-032 bcd_in=20'h00000, blank_lz=1 -> digit 0 asserted, seg=1000000; bcd_in=20'h0000A -> digit 0 seg=0111111.
REQ-033 Change bcd_in from 20'h11111 to 20'h22222 at mid-frame -> the remaining slots of that frame show 1; 2 appears only after the next frame_done; frame_done is high exactly 1 cycle in every 32.
REQ-034 en=0 for one full frame -> an=FF and seg=7F throughout while frame_done keeps pulsing; rst=1 at idx=3 -> next cycle matches REQ-025, and the display shows "0" until the first new frame_done.
